// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: cell/result codes, board size and bot helpers.
package ttt_pkg;

  localparam logic [1:0] EMPTY  = 2'b00;
  localparam logic [1:0] CELL_O = 2'b01;
  localparam logic [1:0] CELL_X = 2'b11;

  localparam logic [1:0] NONE = 2'd0;
  localparam logic [1:0] XWIN = 2'd1;
  localparam logic [1:0] OWIN = 2'd2;

  localparam int         NUM_CELLS = 9;
  localparam logic [3:0] BAD_MOVE  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_THINK,
    ST_SCAN,
    ST_STROBE,
    ST_RELEASE
  } bot_state_t;

  // Fold a 4-bit random value into the 0..8 square range.
  function automatic logic [3:0] fold_index(input logic [3:0] v);
    return (v >= 4'(NUM_CELLS)) ? v - 4'(NUM_CELLS) : v;
  endfunction

  function automatic logic [3:0] next_index(input logic [3:0] v);
    return (v == 4'(NUM_CELLS - 1)) ? 4'd0 : v + 4'd1;
  endfunction

endpackage

// File: rtl/auto_user_if.sv
// Move-request handshake between the game FSM (master) and a move source (slave).
interface auto_user_if;
  logic [17:0] i_board;
  logic        i_need_userinput;
  logic        o_user_busy;
  logic [3:0]  o_user_move;
  logic        o_usermove_stb;

  modport master (
    output i_board, i_need_userinput,
    input  o_user_busy, o_user_move, o_usermove_stb
  );

  modport slave (
    input  i_board, i_need_userinput,
    output o_user_busy, o_user_move, o_usermove_stb
  );
endinterface

// File: rtl/auto_user_lfsr16.sv
// Free-running 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1 (right shift).
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic [15:0] o_lfsr
);
  localparam logic [15:0] TAPS = 16'hB400;

  logic [15:0] lfsr_reg;
  logic [15:0] lfsr_next;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_bit
      if (gi == 15) begin : g_top
        assign lfsr_next[gi] = lfsr_reg[0];
      end else begin : g_mid
        assign lfsr_next[gi] = lfsr_reg[gi+1] ^ (TAPS[gi] & lfsr_reg[0]);
      end
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_reset) lfsr_reg <= SEED;
    else         lfsr_reg <= lfsr_next;
  end

  assign o_lfsr = lfsr_reg;
endmodule

// File: rtl/auto_user.sv
// Self-play O opponent: random empty square after a think delay, plus outcome tallies.
// Optional build macro AUTO_USER_STATS_EN enables the outcome statistics counters.
module auto_user
  import ttt_pkg::*;
#(
  parameter int          THINK_CYCLES = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          COUNT_W      = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  auto_user_if.slave         mv,
  input  logic [1:0]         i_result,
  input  logic               i_isdraw,
  input  logic               i_result_stb,
  output logic [COUNT_W-1:0] o_games,
  output logic [COUNT_W-1:0] o_xwins,
  output logic [COUNT_W-1:0] o_owins,
  output logic [COUNT_W-1:0] o_draws
);
  localparam int            TW         = (THINK_CYCLES > 1) ? $clog2(THINK_CYCLES) : 1;
  localparam logic [TW-1:0] THINK_INIT = TW'(THINK_CYCLES - 1);

  bot_state_t    state_reg, state_next;
  logic [TW-1:0] think_reg, think_next;
  logic [3:0]    idx_reg, idx_next;
  logic [3:0]    scan_reg, scan_next;
  logic          busy_reg, busy_next;
  logic [3:0]    move_reg, move_next;
  logic          stb_reg, stb_next;

  logic [15:0]          lfsr_q;
  logic [NUM_CELLS-1:0] empty_vec;
  logic                 unused_lfsr_bits;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_lfsr  (lfsr_q)
  );
  assign unused_lfsr_bits = ^lfsr_q[15:4];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
      assign empty_vec[gi] = (mv.i_board[2*gi +: 2] == EMPTY);
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg <= ST_IDLE;
      think_reg <= '0;
      idx_reg   <= '0;
      scan_reg  <= '0;
      busy_reg  <= 1'b0;
      move_reg  <= '0;
      stb_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      think_reg <= think_next;
      idx_reg   <= idx_next;
      scan_reg  <= scan_next;
      busy_reg  <= busy_next;
      move_reg  <= move_next;
      stb_reg   <= stb_next;
    end
  end

  // The strobe register is loaded on the transition into STROBE so it is high
  // exactly while the FSM sits in STROBE.
  always_comb begin
    state_next = state_reg;
    think_next = think_reg;
    idx_next   = idx_reg;
    scan_next  = scan_reg;
    busy_next  = busy_reg;
    move_next  = move_reg;
    stb_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (mv.i_need_userinput) begin
          busy_next  = 1'b1;
          think_next = THINK_INIT;
          idx_next   = fold_index(lfsr_q[3:0]);
          state_next = ST_THINK;
        end
      end
      ST_THINK: begin
        if (!mv.i_need_userinput) begin
          busy_next  = 1'b0;
          state_next = ST_IDLE;
        end else if (think_reg == '0) begin
          scan_next  = '0;
          state_next = ST_SCAN;
        end else begin
          think_next = think_reg - TW'(1);
        end
      end
      ST_SCAN: begin
        if (!mv.i_need_userinput) begin
          busy_next  = 1'b0;
          state_next = ST_IDLE;
        end else if (empty_vec[idx_reg]) begin
          move_next  = idx_reg;
          busy_next  = 1'b0;
          stb_next   = 1'b1;
          state_next = ST_STROBE;
        end else if (scan_reg == 4'(NUM_CELLS - 1)) begin
          move_next  = BAD_MOVE;
          busy_next  = 1'b0;
          stb_next   = 1'b1;
          state_next = ST_STROBE;
        end else begin
          idx_next  = next_index(idx_reg);
          scan_next = scan_reg + 4'd1;
        end
      end
      ST_STROBE: begin
        state_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        // Hold off until the request is withdrawn so one request gets one answer.
        if (!mv.i_need_userinput) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign mv.o_user_busy    = busy_reg;
  assign mv.o_user_move    = move_reg;
  assign mv.o_usermove_stb = stb_reg;

`ifdef AUTO_USER_STATS_EN
  logic                          stb_prev_reg;
  logic                          rise;
  logic [3:0]                    inc;
  logic [3:0][COUNT_W-1:0]       cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) stb_prev_reg <= 1'b0;
    else         stb_prev_reg <= i_result_stb;
  end

  assign rise   = i_result_stb & ~stb_prev_reg;
  // Index order: games, draws, X wins, O wins; a draw outranks any result code.
  assign inc[0] = rise;
  assign inc[1] = rise & i_isdraw;
  assign inc[2] = rise & ~i_isdraw & (i_result == XWIN);
  assign inc[3] = rise & ~i_isdraw & (i_result == OWIN);

  generate
    for (gi = 0; gi < 4; gi++) begin : g_cnt
      logic [COUNT_W-1:0] cnt_reg;
      always_ff @(posedge i_clk) begin
        if (i_reset)
          cnt_reg <= '0;
        else if (inc[gi] && (cnt_reg != '1))
          cnt_reg <= cnt_reg + COUNT_W'(1);
      end
      assign cnt_q[gi] = cnt_reg;
    end
  endgenerate

  assign o_games = cnt_q[0];
  assign o_draws = cnt_q[1];
  assign o_xwins = cnt_q[2];
  assign o_owins = cnt_q[3];
`else
  logic unused_stats;
  assign unused_stats = ^{i_result, i_isdraw, i_result_stb};

  assign o_games = '0;
  assign o_xwins = '0;
  assign o_owins = '0;
  assign o_draws = '0;
`endif

endmodule
